// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - shared encodings and control bundle for the pipeline control unit
package cpu_ctrl_pkg;

  localparam int CTRL_OPW = 6;

  localparam logic [CTRL_OPW-1:0] OP_RTYPE = 6'h00;
  localparam logic [CTRL_OPW-1:0] OP_J     = 6'h02;
  localparam logic [CTRL_OPW-1:0] OP_BEQ   = 6'h04;
  localparam logic [CTRL_OPW-1:0] OP_ADDI  = 6'h08;
  localparam logic [CTRL_OPW-1:0] OP_ANDI  = 6'h0C;
  localparam logic [CTRL_OPW-1:0] OP_ORI   = 6'h0D;
  localparam logic [CTRL_OPW-1:0] OP_LW    = 6'h23;
  localparam logic [CTRL_OPW-1:0] OP_SW    = 6'h2B;

  localparam logic [CTRL_OPW-1:0] FN_ADD = 6'h20;
  localparam logic [CTRL_OPW-1:0] FN_SUB = 6'h22;
  localparam logic [CTRL_OPW-1:0] FN_AND = 6'h24;
  localparam logic [CTRL_OPW-1:0] FN_OR  = 6'h25;
  localparam logic [CTRL_OPW-1:0] FN_SLT = 6'h2A;

  // ALU op codes reuse the R-type funct encoding so R-type can pass funct straight through
  localparam logic [CTRL_OPW-1:0] ALU_ADD = FN_ADD;
  localparam logic [CTRL_OPW-1:0] ALU_SUB = FN_SUB;
  localparam logic [CTRL_OPW-1:0] ALU_AND = FN_AND;
  localparam logic [CTRL_OPW-1:0] ALU_OR  = FN_OR;
  localparam logic [CTRL_OPW-1:0] ALU_SLT = FN_SLT;

  typedef enum logic [1:0] {
    PCSEL_SEQ = 2'd0,
    PCSEL_BR  = 2'd1,
    PCSEL_JMP = 2'd2
  } pc_sel_e;

  typedef struct packed {
    logic [CTRL_OPW-1:0] alu_op;
    logic                r;
    logic                i;
    logic                j;
    logic                wreg;
    logic                wmem;
    logic                from_mem;
    logic                branch;
  } ctrl_bundle_t;

  localparam ctrl_bundle_t CTRL_NOP = '0;

endpackage

// File: rtl/ctrl_decoder.sv
// rtl/ctrl_decoder.sv - combinational opcode/funct to control bundle decode
module ctrl_decoder
  import cpu_ctrl_pkg::*;
(
  input  logic [CTRL_OPW-1:0] opcode_i,
  input  logic [CTRL_OPW-1:0] funct_i,
  output ctrl_bundle_t        bundle_o,
  output logic                illegal_o
);

  always_comb begin
    bundle_o  = CTRL_NOP;
    illegal_o = 1'b0;
    case (opcode_i)
      OP_RTYPE: begin
        case (funct_i)
          FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: begin
            bundle_o.alu_op = funct_i;
            bundle_o.r      = 1'b1;
            bundle_o.wreg   = 1'b1;
          end
          default: illegal_o = 1'b1;
        endcase
      end
      OP_ADDI: begin
        bundle_o.i      = 1'b1;
        bundle_o.alu_op = ALU_ADD;
        bundle_o.wreg   = 1'b1;
      end
      OP_ANDI: begin
        bundle_o.i      = 1'b1;
        bundle_o.alu_op = ALU_AND;
        bundle_o.wreg   = 1'b1;
      end
      OP_ORI: begin
        bundle_o.i      = 1'b1;
        bundle_o.alu_op = ALU_OR;
        bundle_o.wreg   = 1'b1;
      end
      OP_LW: begin
        bundle_o.i        = 1'b1;
        bundle_o.alu_op   = ALU_ADD;
        bundle_o.wreg     = 1'b1;
        bundle_o.from_mem = 1'b1;
      end
      OP_SW: begin
        bundle_o.i      = 1'b1;
        bundle_o.alu_op = ALU_ADD;
        bundle_o.wmem   = 1'b1;
      end
      OP_BEQ: begin
        bundle_o.alu_op = ALU_SUB;
        bundle_o.branch = 1'b1;
      end
      OP_J: bundle_o.j = 1'b1;
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/pipeline_control_unit.sv
// rtl/pipeline_control_unit.sv - stage-aligned control pipeline with branch/jump redirect and squash
module pipeline_control_unit
  import cpu_ctrl_pkg::*;
#(
  parameter int OPW  = 6,
  parameter int PCSW = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [OPW-1:0]  opcode,
  input  logic [OPW-1:0]  funct,
  input  logic            EX_MEM_is_alu_zero,
  input  logic            is_IDEX_open,
  input  logic            is_EXMEM_open,
  input  logic            is_MEMWB_open,
  output logic [OPW-1:0]  opcode_alu,
  output logic            is_R_type,
  output logic            is_I_type,
  output logic            is_J_type,
  output logic            is_write_mem,
  output logic            is_write_reg,
  output logic            is_write_from_mem,
  output logic [PCSW-1:0] control_mux_for_PC,
  output logic            illegal_op
);

  ctrl_bundle_t dec_bundle;
  logic         dec_illegal;

  ctrl_bundle_t idex_q, idex_d;
  ctrl_bundle_t exmem_q, exmem_d;
  ctrl_bundle_t memwb_q, memwb_d;
  logic         kill_q, kill_d;
  logic         illegal_q, illegal_d;
  logic         br_taken;
  pc_sel_e      pc_sel;

  ctrl_decoder u_dec (
    .opcode_i  (CTRL_OPW'(opcode)),
    .funct_i   (CTRL_OPW'(funct)),
    .bundle_o  (dec_bundle),
    .illegal_o (dec_illegal)
  );

  assign br_taken = exmem_q.branch & EX_MEM_is_alu_zero;

  // The branch sits one stage further along than the jump, so it takes priority
  always_comb begin
    pc_sel = PCSEL_SEQ;
    if (br_taken) begin
      pc_sel = PCSEL_BR;
    end else if (idex_q.j) begin
      pc_sel = PCSEL_JMP;
    end
  end

  always_comb begin
    memwb_d   = is_MEMWB_open ? exmem_q : memwb_q;
    exmem_d   = exmem_q;
    idex_d    = idex_q;
    kill_d    = kill_q;
    illegal_d = illegal_q | (is_IDEX_open & dec_illegal);
    if (br_taken && is_EXMEM_open) begin
      exmem_d = CTRL_NOP;
      idex_d  = CTRL_NOP;
      kill_d  = 1'b1;
    end else begin
      if (is_EXMEM_open) begin
        exmem_d = idex_q;
      end
      if (is_IDEX_open) begin
        if (idex_q.j && !br_taken) begin
          idex_d = CTRL_NOP;
          kill_d = 1'b1;
        end else if (kill_q) begin
          // One fetch slot after a redirect is still wrong-path
          idex_d = CTRL_NOP;
          kill_d = 1'b0;
        end else begin
          idex_d = dec_bundle;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idex_q    <= CTRL_NOP;
      exmem_q   <= CTRL_NOP;
      memwb_q   <= CTRL_NOP;
      kill_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      idex_q    <= idex_d;
      exmem_q   <= exmem_d;
      memwb_q   <= memwb_d;
      kill_q    <= kill_d;
      illegal_q <= illegal_d;
    end
  end

  assign opcode_alu         = OPW'(idex_q.alu_op);
  assign is_R_type          = idex_q.r;
  assign is_I_type          = idex_q.i;
  assign is_J_type          = idex_q.j;
  assign is_write_mem       = exmem_q.wmem;
  assign is_write_reg       = memwb_q.wreg;
  assign is_write_from_mem  = memwb_q.from_mem;
  assign control_mux_for_PC = PCSW'(pc_sel);
  assign illegal_op         = illegal_q;

endmodule

// File: tb/tb_pipeline_control_unit.sv
// tb/tb_pipeline_control_unit.sv - self-checking bench for pipeline_control_unit
module tb_pipeline_control_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode, funct;
  logic       zero, ieo, emo, mwo;
  logic [5:0] opcode_alu;
  logic       is_R_type, is_I_type, is_J_type;
  logic       is_write_mem, is_write_reg, is_write_from_mem;
  logic [1:0] control_mux_for_PC;
  logic       illegal_op;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pipeline_control_unit #(.OPW(6), .PCSW(2)) dut (
    .clk                (clk),
    .rst                (rst),
    .opcode             (opcode),
    .funct              (funct),
    .EX_MEM_is_alu_zero (zero),
    .is_IDEX_open       (ieo),
    .is_EXMEM_open      (emo),
    .is_MEMWB_open      (mwo),
    .opcode_alu         (opcode_alu),
    .is_R_type          (is_R_type),
    .is_I_type          (is_I_type),
    .is_J_type          (is_J_type),
    .is_write_mem       (is_write_mem),
    .is_write_reg       (is_write_reg),
    .is_write_from_mem  (is_write_from_mem),
    .control_mux_for_PC (control_mux_for_PC),
    .illegal_op         (illegal_op)
  );

  typedef struct packed {
    logic [5:0] alu;
    logic r, i, j, wreg, wmem, fm, br, ill;
  } exp_t;

  // Reference pipeline holds instruction words ({opcode,funct}); -1 marks a bubble
  int m_idex, m_exmem, m_memwb;
  bit m_kill, m_ill, m_valid;

  function automatic exp_t ref_decode(int ins);
    exp_t e;
    logic [5:0] op, fn;
    e = '0;
    if (ins < 0) return e;
    op = ins[11:6];
    fn = ins[5:0];
    case (op)
      6'h00: if (fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A}) begin
               e.alu = fn; e.r = 1; e.wreg = 1;
             end else e.ill = 1;
      6'h08: begin e.i = 1; e.alu = 6'h20; e.wreg = 1; end
      6'h0C: begin e.i = 1; e.alu = 6'h24; e.wreg = 1; end
      6'h0D: begin e.i = 1; e.alu = 6'h25; e.wreg = 1; end
      6'h23: begin e.i = 1; e.alu = 6'h20; e.wreg = 1; e.fm = 1; end
      6'h2B: begin e.i = 1; e.alu = 6'h20; e.wmem = 1; end
      6'h04: begin e.alu = 6'h22; e.br = 1; end
      6'h02: e.j = 1;
      default: e.ill = 1;
    endcase
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_ins(input logic [5:0] op, input logic [5:0] fn);
    opcode = op;
    funct  = fn;
  endtask

  task automatic model_edge();
    int ins, n_idex, n_exmem, n_memwb;
    bit br, jmp, n_kill;
    if (rst) begin
      m_idex = -1; m_exmem = -1; m_memwb = -1; m_kill = 0; m_ill = 0; m_valid = 1;
      return;
    end
    ins = int'({opcode, funct});
    br  = ref_decode(m_exmem).br && zero;
    jmp = ref_decode(m_idex).j;
    n_memwb = mwo ? m_exmem : m_memwb;
    n_exmem = m_exmem;
    n_idex  = m_idex;
    n_kill  = m_kill;
    if (br && emo) begin
      n_exmem = -1; n_idex = -1; n_kill = 1;
    end else begin
      if (emo) n_exmem = m_idex;
      if (ieo) begin
        if (jmp && !br) begin n_idex = -1; n_kill = 1; end
        else if (m_kill) begin n_idex = -1; n_kill = 0; end
        else n_idex = ins;
      end
    end
    if (ieo && ref_decode(ins).ill) m_ill = 1;
    m_idex = n_idex; m_exmem = n_exmem; m_memwb = n_memwb; m_kill = n_kill;
  endtask

  task automatic tick();
    exp_t x, xe, xm;
    logic [1:0] exp_pc;
    #1;
    if (m_valid) begin
      x  = ref_decode(m_idex);
      xe = ref_decode(m_exmem);
      exp_pc = (xe.br && zero) ? 2'd1 : (x.j ? 2'd2 : 2'd0);
      chk("pc_sel_pre", 32'(control_mux_for_PC), 32'(exp_pc));
    end
    @(posedge clk);
    model_edge();
    #1;
    x  = ref_decode(m_idex);
    xe = ref_decode(m_exmem);
    xm = ref_decode(m_memwb);
    chk("opcode_alu", 32'(opcode_alu), 32'(x.alu));
    chk("is_R_type", 32'(is_R_type), 32'(x.r));
    chk("is_I_type", 32'(is_I_type), 32'(x.i));
    chk("is_J_type", 32'(is_J_type), 32'(x.j));
    chk("is_write_mem", 32'(is_write_mem), 32'(xe.wmem));
    chk("is_write_reg", 32'(is_write_reg), 32'(xm.wreg));
    chk("is_write_from_mem", 32'(is_write_from_mem), 32'(xm.fm));
    chk("illegal_op", 32'(illegal_op), 32'(m_ill));
  endtask

  logic [5:0] ops[9] = '{6'h00, 6'h08, 6'h0C, 6'h0D, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h00};
  logic [5:0] fns[5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};

  initial begin
    m_valid = 0; m_kill = 0; m_ill = 0;
    m_idex = -1; m_exmem = -1; m_memwb = -1;
    rst = 1; zero = 0; ieo = 1; emo = 1; mwo = 1;
    set_ins(6'h23, 6'h00);

    // Reset
    tick(); tick();
    chk("rst_alu", 32'(opcode_alu), 0);
    chk("rst_wreg", 32'(is_write_reg), 0);
    chk("rst_pc", 32'(control_mux_for_PC), 0);
    chk("rst_illegal", 32'(illegal_op), 0);

    // lw alignment
    rst = 0;
    set_ins(6'h23, 6'h00); tick();
    chk("lw_alu", 32'(opcode_alu), 32'h20);
    chk("lw_itype", 32'(is_I_type), 1);
    set_ins(6'h08, 6'h00); tick();
    chk("lw_wmem", 32'(is_write_mem), 0);
    tick();
    chk("lw_wreg", 32'(is_write_reg), 1);
    chk("lw_from_mem", 32'(is_write_from_mem), 1);

    // sw reaches EX/MEM after two edges
    set_ins(6'h2B, 6'h00); tick(); tick();
    chk("sw_wmem", 32'(is_write_mem), 1);

    // Taken beq followed by adds
    zero = 1;
    set_ins(6'h04, 6'h00); tick();
    set_ins(6'h00, 6'h20); tick();
    chk("beq_taken_pc", 32'(control_mux_for_PC), 1);
    tick();
    chk("beq_taken_pc_drop", 32'(control_mux_for_PC), 0);
    tick();
    chk("beq_sq1", 32'(is_write_reg), 0);
    tick();
    chk("beq_sq2", 32'(is_write_reg), 0);
    tick();
    chk("beq_sq3", 32'(is_write_reg), 0);
    tick();
    chk("beq_resume", 32'(is_write_reg), 1);

    // Not-taken beq
    zero = 0;
    set_ins(6'h04, 6'h00); tick();
    set_ins(6'h00, 6'h22); tick();
    chk("beq_nt_pc", 32'(control_mux_for_PC), 0);
    tick(); tick();
    chk("beq_nt_wreg", 32'(is_write_reg), 1);

    // Jump
    set_ins(6'h02, 6'h00); tick();
    chk("j_pc", 32'(control_mux_for_PC), 2);
    chk("j_type", 32'(is_J_type), 1);
    set_ins(6'h00, 6'h20); tick();
    chk("j_pc_drop", 32'(control_mux_for_PC), 0);
    chk("j_squash_alu", 32'(opcode_alu), 0);
    tick(); tick();
    chk("j_proceed_alu", 32'(opcode_alu), 32'h20);

    // Stall a taken beq in EX/MEM
    zero = 1;
    set_ins(6'h04, 6'h00); tick();
    set_ins(6'h00, 6'h25); tick();
    ieo = 0; emo = 0; tick();
    chk("stall_pc1", 32'(control_mux_for_PC), 1);
    tick();
    chk("stall_pc2", 32'(control_mux_for_PC), 1);
    ieo = 1; emo = 1; tick();
    chk("stall_release_pc", 32'(control_mux_for_PC), 0);
    zero = 0;
    tick(); tick(); tick();

    // Illegal opcode is sticky until reset
    set_ins(6'h3F, 6'h00); tick();
    chk("illegal_set", 32'(illegal_op), 1);
    chk("illegal_nop", 32'(opcode_alu), 0);
    set_ins(6'h00, 6'h20); tick(); tick();
    chk("illegal_sticky", 32'(illegal_op), 1);
    rst = 1; tick();
    chk("illegal_clear", 32'(illegal_op), 0);
    rst = 0;

    // Randomized traffic against the reference model
    for (int k = 0; k < 600; k++) begin
      rst  = ($urandom_range(0, 49) == 0);
      ieo  = ($urandom_range(0, 3) != 0);
      emo  = ($urandom_range(0, 3) != 0);
      mwo  = ($urandom_range(0, 3) != 0);
      zero = $urandom_range(0, 1);
      if ($urandom_range(0, 29) == 0) begin
        set_ins(6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)));
      end else begin
        set_ins(ops[$urandom_range(0, 8)], fns[$urandom_range(0, 4)]);
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
